// File: rtl/rggen_rtl_pkg.sv
// -----------------------------------------------------------------------------
// rggen_rtl_pkg
// Shared types for the rggen register-block RTL.
//   rggen_w1s_req_state_e : per-bit state of a software-to-hardware request
//                           bit field (IDLE -> PENDING -> BUSY -> IDLE).
// -----------------------------------------------------------------------------
package rggen_rtl_pkg;

    typedef enum logic [1:0] {
        RGGEN_W1S_REQ_IDLE    = 2'b00,
        RGGEN_W1S_REQ_PENDING = 2'b01,
        RGGEN_W1S_REQ_BUSY    = 2'b10
    } rggen_w1s_req_state_e;

endpackage

// File: rtl/rggen_bit_field_if.sv
// -----------------------------------------------------------------------------
// rggen_bit_field_if
// Software access path between the register block and one bit field.
//   valid      : access strobe from the register block
//   write_mask : per-bit write enable
//   write_data : write value
//   read_data  : value returned to software on a read
//   value      : current field value for the rest of the register block
// Modports:
//   master    : register-block side (drives valid/mask/data)
//   slave     : bit-field side
//   bit_field : alias of slave, the name bit-field modules bind to
// -----------------------------------------------------------------------------
interface rggen_bit_field_if #(
    parameter int unsigned WIDTH = 8
);
    logic             valid;
    logic [WIDTH-1:0] write_mask;
    logic [WIDTH-1:0] write_data;
    logic [WIDTH-1:0] read_data;
    logic [WIDTH-1:0] value;

    modport master (
        output valid,
        output write_mask,
        output write_data,
        input  read_data,
        input  value
    );

    modport slave (
        input  valid,
        input  write_mask,
        input  write_data,
        output read_data,
        output value
    );

    modport bit_field (
        input  valid,
        input  write_mask,
        input  write_data,
        output read_data,
        output value
    );
endinterface

// File: rtl/rggen_bit_field_w1s_req_slice.sv
// -----------------------------------------------------------------------------
// rggen_bit_field_w1s_req_slice
// One bit of a write-1-to-set request field with req/ack/done handshake.
// Optional feature macro: RGGEN_BIT_FIELD_W1S_REQ_TIMEOUT_EN (BUSY timeout).
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_set          : software set event for this bit
//   i_ack, i_done  : hardware acknowledge / completion
//   o_request      : state is PENDING
//   o_busy         : state is not IDLE
//   o_overrun      : one-cycle pulse, set rejected because the bit was not IDLE
//   o_timeout      : one-cycle pulse, BUSY aborted by timeout (0 if disabled)
// -----------------------------------------------------------------------------
module rggen_bit_field_w1s_req_slice
    import rggen_rtl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned TIMEOUT_WIDTH  = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_set,
    input  logic i_ack,
    input  logic i_done,
    output logic o_request,
    output logic o_busy,
    output logic o_overrun,
    output logic o_timeout
);

    rggen_w1s_req_state_e r_state;
    logic                 r_overrun;
    logic                 r_timeout;
    logic                 w_timeout_hit;

`ifdef RGGEN_BIT_FIELD_W1S_REQ_TIMEOUT_EN
    logic [TIMEOUT_WIDTH-1:0] r_count;

    // Counter holds (BUSY cycles - 1); the edge closing the TIMEOUT_CYCLES-th
    // BUSY cycle aborts.
    assign w_timeout_hit = (r_count == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (r_state == RGGEN_W1S_REQ_PENDING && i_ack) begin
            r_count <= '0;
        end else if (r_state == RGGEN_W1S_REQ_BUSY && !w_timeout_hit) begin
            r_count <= r_count + 1'b1;
        end
    end
`else
    logic w_unused_cfg;

    assign w_unused_cfg  = ^{TIMEOUT_CYCLES, TIMEOUT_WIDTH};
    assign w_timeout_hit = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= RGGEN_W1S_REQ_IDLE;
            r_overrun <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            // A set is never queued; any set outside IDLE is reported.
            r_overrun <= i_set && (r_state != RGGEN_W1S_REQ_IDLE);
            r_timeout <= 1'b0;
            case (r_state)
                RGGEN_W1S_REQ_IDLE: begin
                    if (i_set) begin
                        r_state <= RGGEN_W1S_REQ_PENDING;
                    end
                end
                RGGEN_W1S_REQ_PENDING: begin
                    if (i_ack) begin
                        r_state <= RGGEN_W1S_REQ_BUSY;
                    end
                end
                RGGEN_W1S_REQ_BUSY: begin
                    // done wins over a simultaneous timeout
                    if (i_done) begin
                        r_state <= RGGEN_W1S_REQ_IDLE;
                    end else if (w_timeout_hit) begin
                        r_state   <= RGGEN_W1S_REQ_IDLE;
                        r_timeout <= 1'b1;
                    end
                end
                default: begin
                    r_state <= RGGEN_W1S_REQ_IDLE;
                end
            endcase
        end
    end

    assign o_request = (r_state == RGGEN_W1S_REQ_PENDING);
    assign o_busy    = (r_state != RGGEN_W1S_REQ_IDLE);
    assign o_overrun = r_overrun;
    assign o_timeout = r_timeout;

endmodule

// File: rtl/rggen_bit_field_w1s_req.sv
// -----------------------------------------------------------------------------
// rggen_bit_field_w1s_req
// Software-to-hardware request bit field: software writes 1 to post a request,
// hardware consumes it via request/ack/done. One independent slice per bit.
// Optional feature macro: RGGEN_BIT_FIELD_W1S_REQ_TIMEOUT_EN (BUSY timeout).
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   bit_field_if   : software access (read_data = value = o_busy)
//   o_request      : per-bit request level to hardware
//   i_ack, i_done  : per-bit acknowledge / completion from hardware
//   o_busy         : per-bit PENDING or BUSY
//   o_overrun      : per-bit one-cycle pulse on a rejected set
//   o_timeout      : per-bit one-cycle pulse on BUSY timeout abort
// -----------------------------------------------------------------------------
module rggen_bit_field_w1s_req
    import rggen_rtl_pkg::*;
#(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned TIMEOUT_WIDTH  = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    rggen_bit_field_if.bit_field    bit_field_if,
    output logic [WIDTH-1:0]        o_request,
    input  logic [WIDTH-1:0]        i_ack,
    input  logic [WIDTH-1:0]        i_done,
    output logic [WIDTH-1:0]        o_busy,
    output logic [WIDTH-1:0]        o_overrun,
    output logic [WIDTH-1:0]        o_timeout
);

    logic [WIDTH-1:0] w_set;

    assign w_set = {WIDTH{bit_field_if.valid}} & bit_field_if.write_mask
                 & bit_field_if.write_data;

    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        rggen_bit_field_w1s_req_slice #(
            .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
            .TIMEOUT_WIDTH  (TIMEOUT_WIDTH)
        ) u_slice (
            .i_clk     (i_clk),
            .i_rst_n   (i_rst_n),
            .i_set     (w_set[i]),
            .i_ack     (i_ack[i]),
            .i_done    (i_done[i]),
            .o_request (o_request[i]),
            .o_busy    (o_busy[i]),
            .o_overrun (o_overrun[i]),
            .o_timeout (o_timeout[i])
        );
    end

    assign bit_field_if.read_data = o_busy;
    assign bit_field_if.value     = o_busy;

endmodule

// File: tb/tb_rggen_bit_field_w1s_req.sv
// -----------------------------------------------------------------------------
// tb_rggen_bit_field_w1s_req
// Directed bench: each step drives one cycle of stimulus, queues the expected
// outputs for after the next edge, then pops and compares them.
// -----------------------------------------------------------------------------
module tb_rggen_bit_field_w1s_req;

    localparam int unsigned WIDTH = 8;
`ifdef RGGEN_BIT_FIELD_W1S_REQ_TIMEOUT_EN
    localparam int unsigned TMO = 4;
`else
    localparam int unsigned TMO = 1024;
`endif

    typedef struct {
        string      tag;
        logic [7:0] req;
        logic [7:0] busy;
        logic [7:0] ovr;
        logic [7:0] tmo;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] ack;
    logic [WIDTH-1:0] done;
    logic [WIDTH-1:0] request;
    logic [WIDTH-1:0] busy;
    logic [WIDTH-1:0] overrun;
    logic [WIDTH-1:0] timeout;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    rggen_bit_field_if #(.WIDTH(WIDTH)) bf_if ();

    rggen_bit_field_w1s_req #(
        .WIDTH          (WIDTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .bit_field_if (bf_if),
        .o_request    (request),
        .i_ack        (ack),
        .i_done       (done),
        .o_busy       (busy),
        .o_overrun    (overrun),
        .o_timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic push(input string tag, input logic [7:0] e_req, input logic [7:0] e_busy,
                        input logic [7:0] e_ovr, input logic [7:0] e_tmo);
        exp_t e;
        e.tag  = tag;
        e.req  = e_req;
        e.busy = e_busy;
        e.ovr  = e_ovr;
        e.tmo  = e_tmo;
        q.push_back(e);
    endtask

    task automatic compare_head();
        exp_t e;
        e = q.pop_front();
        chk({e.tag, ".request"}, request, e.req);
        chk({e.tag, ".busy"}, busy, e.busy);
        chk({e.tag, ".read_data"}, bf_if.read_data, e.busy);
        chk({e.tag, ".value"}, bf_if.value, e.busy);
        chk({e.tag, ".overrun"}, overrun, e.ovr);
        chk({e.tag, ".timeout"}, timeout, e.tmo);
    endtask

    // One cycle: drive inputs, queue expectation, clock, compare 1 ns later.
    task automatic cyc(input string tag, input logic v, input logic [7:0] m,
                       input logic [7:0] d, input logic [7:0] a, input logic [7:0] dn,
                       input logic [7:0] e_req, input logic [7:0] e_busy,
                       input logic [7:0] e_ovr, input logic [7:0] e_tmo);
        bf_if.valid      = v;
        bf_if.write_mask = m;
        bf_if.write_data = d;
        ack              = a;
        done             = dn;
        push(tag, e_req, e_busy, e_ovr, e_tmo);
        @(posedge clk);
        #1;
        compare_head();
    endtask

    initial begin
        rst_n            = 1'b0;
        bf_if.valid      = 1'b0;
        bf_if.write_mask = '0;
        bf_if.write_data = '0;
        ack              = '0;
        done             = '0;
        #12;
        push("reset", 8'h00, 8'h00, 8'h00, 8'h00);
        compare_head();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic handshake: request high exactly 2 cycles, busy until done+1.
        cyc("hs_set",   1'b1, 8'hFF, 8'h01, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00);
        cyc("hs_wait",  1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00);
        cyc("hs_ack",   1'b0, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00);
        cyc("hs_busy1", 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00);
        cyc("hs_busy2", 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00);
        cyc("hs_done",  1'b0, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00);

        // Masking and independent bits.
        cyc("mask_set", 1'b1, 8'h0F, 8'hA5, 8'h00, 8'h00, 8'h05, 8'h05, 8'h00, 8'h00);
        cyc("mask_w0",  1'b1, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h05, 8'h05, 8'h00, 8'h00);
        cyc("mask_ack", 1'b0, 8'h00, 8'h00, 8'h04, 8'h00, 8'h01, 8'h05, 8'h00, 8'h00);
        cyc("mask_ak0", 1'b0, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00);
        cyc("mask_dn",  1'b0, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00);

        // Overrun in BUSY, then set coincident with done.
        cyc("ovr_set",  1'b1, 8'hFF, 8'h08, 8'h00, 8'h00, 8'h08, 8'h08, 8'h00, 8'h00);
        cyc("ovr_ack",  1'b0, 8'h00, 8'h00, 8'h08, 8'h00, 8'h00, 8'h08, 8'h00, 8'h00);
        cyc("ovr_hit",  1'b1, 8'hFF, 8'h08, 8'h00, 8'h00, 8'h00, 8'h08, 8'h08, 8'h00);
        cyc("ovr_end",  1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h08, 8'h00, 8'h00);
        cyc("ovr_done", 1'b1, 8'hFF, 8'h08, 8'h00, 8'h08, 8'h00, 8'h00, 8'h08, 8'h00);
        cyc("ovr_idle", 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);

        // Spurious handshake inputs.
        cyc("spur_idle", 1'b0, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00);
        cyc("spur_set",  1'b1, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h02, 8'h02, 8'h00, 8'h00);
        cyc("spur_dn",   1'b0, 8'h00, 8'h00, 8'h00, 8'h02, 8'h02, 8'h02, 8'h00, 8'h00);
        cyc("spur_ack",  1'b0, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00);
        cyc("spur_fin",  1'b0, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00);

        // Reset mid-operation: bit0 PENDING, bit1 BUSY.
        cyc("rst_set",  1'b1, 8'hFF, 8'h03, 8'h00, 8'h00, 8'h03, 8'h03, 8'h00, 8'h00);
        cyc("rst_ack",  1'b0, 8'h00, 8'h00, 8'h02, 8'h00, 8'h01, 8'h03, 8'h00, 8'h00);
        #2;
        rst_n = 1'b0;
        #1;
        push("rst_async", 8'h00, 8'h00, 8'h00, 8'h00);
        compare_head();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc("rst_rel",  1'b1, 8'hFF, 8'h03, 8'h00, 8'h00, 8'h03, 8'h03, 8'h00, 8'h00);
        cyc("rst_ak",   1'b0, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00);
        cyc("rst_dn",   1'b0, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00);

`ifdef RGGEN_BIT_FIELD_W1S_REQ_TIMEOUT_EN
        // Timeout after 4 BUSY cycles.
        cyc("to_set",  1'b1, 8'hFF, 8'h01, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00);
        cyc("to_ack",  1'b0, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00);
        for (int i = 0; i < 3; i++) begin
            cyc("to_busy", 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00);
        end
        cyc("to_fire", 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01);
        cyc("to_end",  1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        // Done in the 4th BUSY cycle beats the timeout.
        cyc("td_set",  1'b1, 8'hFF, 8'h01, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00);
        cyc("td_ack",  1'b0, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00);
        for (int i = 0; i < 3; i++) begin
            cyc("td_busy", 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00);
        end
        cyc("td_done", 1'b0, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00);
        cyc("td_end",  1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
`else
        // Without timeout, BUSY holds until done.
        cyc("nt_set",  1'b1, 8'hFF, 8'h01, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00);
        cyc("nt_ack",  1'b0, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00);
        for (int i = 0; i < 100; i++) begin
            cyc("nt_busy", 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00);
        end
        cyc("nt_done", 1'b0, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
